// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: turns byte/half/word accesses into word-wide data_mem
// reads/writes with read-modify-write and load extension. Define LSU_MISALIGN_EN to split word-crossing accesses.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for req_valid
    // RD0   | reading word W0
    // RD1   | reading word W1 = W0 + 4 (crossing only)
    // WR0   | writing merged word to W0
    // WR1   | writing merged upper bytes to W1 (crossing store only)
    // DONE  | done pulse, load_data/err valid
    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE} state_t;

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("lsu_mem_ctrl: DATA_W must be 32");
        end
    endgenerate

    state_t              r_state;
    logic                r_we;
    logic [2:0]          r_f3;
    logic [1:0]          r_off;
    logic                r_cross;
    logic [ADDR_W-1:0]   r_w0addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [31:0]         r_w0;
    logic [31:0]         r_w1;

    logic                w_illegal;
    logic                w_in_err;
    logic                w_in_cross;
    logic                w_in_sw_direct;
    logic [31:0]         w_word0;
    logic [31:0]         w_word1;
    logic [63:0]         w_pair;
    logic [4:0]          w_sh;
    logic [63:0]         w_mask;
    logic [63:0]         w_merged;
    logic [31:0]         w_ld_src;
    logic [31:0]         w_load;

    assign w_illegal = req_we ? (funct3[2] | (funct3[1:0] == 2'b11))
                              : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
    assign w_in_sw_direct = req_we & (funct3[1:0] == 2'b10) & (addr[1:0] == 2'b00);

`ifdef LSU_MISALIGN_EN
    logic [2:0] w_in_size;
    always_comb begin
        w_in_size = 3'd4;
        case (funct3[1:0])
            2'b00:   w_in_size = 3'd1;
            2'b01:   w_in_size = 3'd2;
            default: w_in_size = 3'd4;
        endcase
    end
    assign w_in_cross = (({1'b0, addr[1:0]} + w_in_size) > 3'd4);
    assign w_in_err   = w_illegal;
`else
    assign w_in_cross = 1'b0;
    assign w_in_err   = w_illegal
                      | ((funct3[1:0] == 2'b01) & addr[0])
                      | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`endif

    // Whichever word is on the bus this cycle is used live; the other comes from the capture regs.
    assign w_word0  = (r_state == S_RD0) ? mem_rdata : r_w0;
    assign w_word1  = (r_state == S_RD1) ? mem_rdata : r_w1;
    assign w_pair   = {w_word1, w_word0};
    assign w_sh     = {r_off, 3'b000};
    assign w_merged = (w_pair & ~(w_mask << w_sh)) | (({32'h0, r_wdata} & w_mask) << w_sh);
    assign w_ld_src = 32'(w_pair >> w_sh);

    always_comb begin
        w_mask = 64'hFFFF_FFFF;
        case (r_f3[1:0])
            2'b00:   w_mask = 64'h0000_00FF;
            2'b01:   w_mask = 64'h0000_FFFF;
            default: w_mask = 64'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        w_load = 32'h0;
        case (r_f3)
            3'b000:  w_load = {{24{w_ld_src[7]}}, w_ld_src[7:0]};
            3'b001:  w_load = {{16{w_ld_src[15]}}, w_ld_src[15:0]};
            3'b010:  w_load = w_ld_src;
            3'b100:  w_load = {24'h0, w_ld_src[7:0]};
            3'b101:  w_load = {16'h0, w_ld_src[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_cross   <= 1'b0;
            r_w0addr  <= '0;
            r_wdata   <= '0;
            r_w0      <= 32'h0;
            r_w1      <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    load_data <= '0;
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_f3     <= funct3;
                        r_off    <= addr[1:0];
                        r_cross  <= w_in_cross;
                        r_w0addr <= {addr[ADDR_W-1:2], 2'b00};
                        r_wdata  <= wdata;
                        if (w_in_err) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (w_in_sw_direct) begin
                            r_state   <= S_WR0;
                            mem_we    <= 1'b1;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata;
                        end else begin
                            r_state  <= S_RD0;
                            mem_re   <= 1'b1;
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                S_RD0: begin
                    r_w0 <= mem_rdata;
                    if (r_cross) begin
                        r_state  <= S_RD1;
                        mem_re   <= 1'b1;
                        mem_addr <= r_w0addr + ADDR_W'(4);
                    end else if (r_we) begin
                        r_state   <= S_WR0;
                        r_w1      <= w_merged[63:32];
                        mem_we    <= 1'b1;
                        mem_addr  <= r_w0addr;
                        mem_wdata <= w_merged[31:0];
                    end else begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        load_data <= w_load;
                    end
                end
`ifdef LSU_MISALIGN_EN
                S_RD1: begin
                    if (r_we) begin
                        r_state   <= S_WR0;
                        r_w1      <= w_merged[63:32];
                        mem_we    <= 1'b1;
                        mem_addr  <= r_w0addr;
                        mem_wdata <= w_merged[31:0];
                    end else begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        load_data <= w_load;
                    end
                end
                S_WR1: begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end
`endif
                S_WR0: begin
`ifdef LSU_MISALIGN_EN
                    if (r_cross) begin
                        r_state   <= S_WR1;
                        mem_we    <= 1'b1;
                        mem_addr  <= r_w0addr + ADDR_W'(4);
                        mem_wdata <= r_w1;
                    end else begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
`else
                    r_state <= S_DONE;
                    done    <= 1'b1;
`endif
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    load_data <= '0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    load_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory; covers both
// LSU_MISALIGN_EN builds.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [31:0] pre_w63;
    logic [31:0] pre_w0;

    int n_chk;
    int n_fail;

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_re ? mem[mem_addr[7:2]] : 32'h0;

    // Single owner of the memory array: preload requests and DUT writes.
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899AABB;
            mem[5]  <= 32'hCCDDEEFF;
            mem[63] <= pre_w63;
            mem[0]  <= pre_w0;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] w63, input logic [31:0] w0);
        @(negedge clk);
        pre_w63 = w63;
        pre_w0  = w0;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Issues one request from IDLE; reports done cycle (0 on timeout), err, load data
    // and whether any read/write strobe was seen.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int dcyc, output logic derr,
                           output logic [31:0] dld, output logic any_re, output logic any_we);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        dcyc   = 0;
        derr   = 1'b0;
        dld    = 32'h0;
        any_re = 1'b0;
        any_we = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_re) any_re = 1'b1;
            if (mem_we) any_we = 1'b1;
            if (done) begin
                dcyc = c;
                derr = err;
                dld  = load_data;
                break;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk_eq("done_pulse", {31'h0, done}, 32'h0);
    endtask

    int          dc;
    logic        de;
    logic [31:0] dl;
    logic        sre;
    logic        swe;
    int          waited;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        pre_en    = 1'b0;
        pre_w63   = 32'h0;
        pre_w0    = 32'h0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_done",  {31'h0, done}, 32'h0);
        chk_eq("rst_err",   {31'h0, err}, 32'h0);
        chk_eq("rst_memre", {31'h0, mem_re}, 32'h0);
        chk_eq("rst_memwe", {31'h0, mem_we}, 32'h0);
        chk_eq("rst_ld",    load_data, 32'h0);
        chk_eq("rst_addr",  mem_addr, 32'h0);
        chk_eq("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        preload(32'h44332211, 32'h88776655);

        run_req(1'b0, 3'b000, 32'h11, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lb_ld", dl, 32'hFFFFFFAA);
        chk_eq("lb_cyc", dc, 2);
        chk_eq("lb_err", {31'h0, de}, 32'h0);

        run_req(1'b0, 3'b100, 32'h11, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lbu_ld", dl, 32'h000000AA);
        chk_eq("lbu_cyc", dc, 2);

        run_req(1'b0, 3'b001, 32'h12, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lh_ld", dl, 32'hFFFF8899);
        chk_eq("lh_cyc", dc, 2);

        run_req(1'b0, 3'b101, 32'h10, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lhu_ld", dl, 32'h0000AABB);

        run_req(1'b0, 3'b010, 32'h14, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lw_ld", dl, 32'hCCDDEEFF);
        chk_eq("lw_cyc", dc, 2);

        run_req(1'b1, 3'b000, 32'h12, 32'h00000055, dc, de, dl, sre, swe);
        chk_eq("sb_mem", mem[4], 32'h8855AABB);
        chk_eq("sb_cyc", dc, 3);
        chk_eq("sb_re", {31'h0, sre}, 32'h1);

        run_req(1'b1, 3'b010, 32'h10, 32'h12345678, dc, de, dl, sre, swe);
        chk_eq("sw_mem", mem[4], 32'h12345678);
        chk_eq("sw_cyc", dc, 2);
        chk_eq("sw_no_re", {31'h0, sre}, 32'h0);

        run_req(1'b1, 3'b001, 32'h16, 32'hABCD1234, dc, de, dl, sre, swe);
        chk_eq("sh_mem", mem[5], 32'h1234EEFF);
        chk_eq("sh_cyc", dc, 3);

        preload(32'h44332211, 32'h88776655);
        run_req(1'b0, 3'b010, 32'h13, 32'h0, dc, de, dl, sre, swe);
`ifdef LSU_MISALIGN_EN
        chk_eq("lw_x_ld", dl, 32'hDDEEFF88);
        chk_eq("lw_x_cyc", dc, 3);
        chk_eq("lw_x_err", {31'h0, de}, 32'h0);
`else
        chk_eq("lw_mis_err", {31'h0, de}, 32'h1);
        chk_eq("lw_mis_cyc", dc, 1);
        chk_eq("lw_mis_acc", {30'h0, sre, swe}, 32'h0);
`endif

        run_req(1'b1, 3'b001, 32'h13, 32'h0000BEEF, dc, de, dl, sre, swe);
`ifdef LSU_MISALIGN_EN
        chk_eq("sh_x_w0", mem[4], 32'hEF99AABB);
        chk_eq("sh_x_w1", mem[5], 32'hCCDDEEBE);
        chk_eq("sh_x_cyc", dc, 5);
`else
        chk_eq("sh_mis_err", {31'h0, de}, 32'h1);
        chk_eq("sh_mis_cyc", dc, 1);
        chk_eq("sh_mis_acc", {30'h0, sre, swe}, 32'h0);
        chk_eq("sh_mis_mem", mem[4], 32'h8899AABB);
`endif

        preload(32'h44332211, 32'h88776655);
        run_req(1'b0, 3'b001, 32'h11, 32'h0, dc, de, dl, sre, swe);
`ifdef LSU_MISALIGN_EN
        chk_eq("lh_mis_ld", dl, 32'hFFFF99AA);
        chk_eq("lh_mis_cyc", dc, 2);
`else
        chk_eq("lh_mis_err", {31'h0, de}, 32'h1);
        chk_eq("lh_mis_cyc", dc, 1);
`endif

`ifdef LSU_MISALIGN_EN
        run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, dc, de, dl, sre, swe);
        chk_eq("lw_wrap_ld", dl, 32'h66554433);
        chk_eq("lw_wrap_cyc", dc, 3);
`endif

        run_req(1'b0, 3'b011, 32'h10, 32'h0, dc, de, dl, sre, swe);
        chk_eq("ill_ld_err", {31'h0, de}, 32'h1);
        chk_eq("ill_ld_cyc", dc, 1);
        chk_eq("ill_ld_acc", {30'h0, sre, swe}, 32'h0);

        run_req(1'b1, 3'b100, 32'h10, 32'h0, dc, de, dl, sre, swe);
        chk_eq("ill_st_err", {31'h0, de}, 32'h1);
        chk_eq("ill_st_cyc", dc, 1);

        // Reset asserted while the SB write strobe is up, before its edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        funct3    = 3'b000;
        addr      = 32'h12;
        wdata     = 32'h00000055;
        waited    = 0;
        while (!mem_we && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk_eq("rst_wr0_seen", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_eq("rst_mid_we",   {31'h0, mem_we}, 32'h0);
        chk_eq("rst_mid_addr", mem_addr, 32'h0);
        chk_eq("rst_mid_wd",   mem_wdata, 32'h0);
        chk_eq("rst_mid_done", {31'h0, done}, 32'h0);
        repeat (2) @(negedge clk);
        chk_eq("rst_mid_mem", mem[4], 32'h8899AABB);
        rst_n = 1'b1;
        run_req(1'b0, 3'b000, 32'h10, 32'h0, dc, de, dl, sre, swe);
        chk_eq("post_rst_ld", dl, 32'hFFFFFFBB);
        chk_eq("post_rst_cyc", dc, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
